// File: rtl/schmidl_cox_preamble_inserter.sv
`default_nettype none
// ============================================================================
// schmidl_cox_preamble_inserter
// Prepends a cyclic prefix and two identical training halves to every frame.
// Revision: 1.0
// ============================================================================
module schmidl_cox_preamble_inserter #(
  parameter int FFT_SIZE = 1024,
  parameter int WIDTH    = 16
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                clear,
  input  logic                                enable,
  input  logic [$clog2(FFT_SIZE/2+1)-1:0]     cp_len,
  input  logic                                cfg_wr_en,
  input  logic [$clog2(FFT_SIZE/2)-1:0]       cfg_wr_addr,
  input  logic [2*WIDTH-1:0]                  cfg_wr_data,
  input  logic [2*WIDTH-1:0]                  i_tdata,
  input  logic                                i_tlast,
  input  logic                                i_tvalid,
  output logic                                i_tready,
  output logic [2*WIDTH-1:0]                  o_tdata,
  output logic                                o_tlast,
  output logic                                o_tvalid,
  input  logic                                o_tready,
  output logic                                busy,
  output logic [31:0]                         frame_count
);

  localparam int HALF = FFT_SIZE / 2;
  localparam int AW   = $clog2(HALF);
  localparam int CW   = $clog2(HALF + 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(HALF - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CP      = 3'd1,
    HALF_A  = 3'd2,
    HALF_B  = 3'd3,
    PAYLOAD = 3'd4
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [AW-1:0]       addr;
  logic [AW-1:0]       addr_next;
  logic [AW-1:0]       rd_addr;
  logic [AW-1:0]       start_addr;
  logic [CW-1:0]       cp_sat;
  logic                en_lat;
  logic                en_next;
  logic                advance;
  logic [2*WIDTH-1:0]  ram [HALF];
  logic [2*WIDTH-1:0]  ram_q;

  assign advance = !o_tvalid || o_tready;
  assign busy    = (state != IDLE);
  assign cp_sat  = (cp_len > CW'(HALF)) ? CW'(HALF) : cp_len;
  // CP covers the tail of the pattern, so it starts at HALF-cp (wraps to 0 for cp=0).
  assign start_addr = AW'(CW'(HALF) - cp_sat);

  // addr is the pattern index entering the output register; rd_addr prefetches the next one.
  always_comb begin
    state_next = state;
    addr_next  = addr;
    en_next    = en_lat;
    rd_addr    = addr + AW'(1);
    i_tready   = 1'b0;
    case (state)
      IDLE: begin
        rd_addr = start_addr;
        if (i_tvalid && advance) begin
          en_next = enable;
          if (!enable) begin
            state_next = PAYLOAD;
          end else begin
            addr_next  = start_addr;
            state_next = (cp_sat == '0) ? HALF_A : CP;
          end
        end
      end
      CP, HALF_A, HALF_B: begin
        if (advance) begin
          addr_next = rd_addr;
          if (addr == LAST_ADDR) begin
            if (state == CP)          state_next = HALF_A;
            else if (state == HALF_A) state_next = HALF_B;
            else                      state_next = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        i_tready = advance && !clear;
        if (i_tvalid && advance && i_tlast) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else if (clear) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr        <= '0;
      en_lat      <= 1'b0;
      o_tvalid    <= 1'b0;
      o_tlast     <= 1'b0;
      o_tdata     <= '0;
      frame_count <= '0;
    end else if (clear) begin
      addr        <= '0;
      en_lat      <= 1'b0;
      o_tvalid    <= 1'b0;
      o_tlast     <= 1'b0;
      o_tdata     <= '0;
      frame_count <= '0;
    end else begin
      addr   <= addr_next;
      en_lat <= en_next;
      if (advance) begin
        case (state)
          CP, HALF_A, HALF_B: begin
            o_tvalid <= 1'b1;
            o_tdata  <= ram_q;
            o_tlast  <= 1'b0;
          end
          PAYLOAD: begin
            o_tvalid <= i_tvalid;
            o_tdata  <= i_tdata;
            o_tlast  <= i_tlast;
          end
          default: begin
            o_tvalid <= 1'b0;
            o_tlast  <= 1'b0;
          end
        endcase
      end
      if (i_tvalid && i_tready && i_tlast && en_lat) begin
        frame_count <= frame_count + 32'd1;
      end
    end
  end

  // Pattern store: plain synchronous block RAM, never reset.
  always_ff @(posedge clk) begin
    if (cfg_wr_en && !busy) begin
      ram[cfg_wr_addr] <= cfg_wr_data;
    end
    if (advance) begin
      ram_q <= ram[rd_addr];
    end
  end

endmodule
`default_nettype wire
